// File: rtl/bram_cart_gen.sv
// bram_cart_gen: Mega CD backup-RAM cartridge controller.
// Decodes the 0x400000-0x7FFFFF cartridge window into the size-ID register,
// the odd-byte RAM window and the write-protect register. It drives a
// byte-wide synchronous BRAM, tracks dirty sectors, and hands the lowest
// dirty sector to the SD-save engine once writes have been idle long enough.
module bram_cart_gen #(
    parameter int ADDR_W   = 17,       // log2 of RAM bytes (13..19)
    parameter int SECT_W   = 9,        // log2 of bytes per dirty sector
    parameter int IDLE_CYC = 1000000   // write-free cycles before a save
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cart_on,
    input  logic [23:0]              cpu_addr,
    input  logic [15:0]              cpu_dato,
    input  logic                     cpu_as_n,
    input  logic                     cpu_oe_n,
    input  logic                     cpu_we_lo_n,
    output logic [15:0]              cart_dout,
    output logic                     cart_oe,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [7:0]               mem_din,
    output logic                     mem_we,
    input  logic [7:0]               mem_dout,
    output logic                     save_req,
    output logic [ADDR_W-SECT_W-1:0] save_sect,
    input  logic                     save_ack,
    output logic                     dirty_any
);

    localparam int          NSECT_W   = ADDR_W - SECT_W;
    localparam int          NSECT     = 1 << NSECT_W;
    localparam logic [23:0] IDLE_LAST = 24'(IDLE_CYC - 1);
    localparam logic [3:0]  ID_CODE   = 4'(ADDR_W - 13);

    typedef enum logic [1:0] {
        REGION_ID       = 2'b00,
        REGION_UNMAPPED = 2'b01,
        REGION_RAM      = 2'b10,
        REGION_WP       = 2'b11
    } region_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_WAIT = 2'b01,
        S_REQ  = 2'b10
    } save_state_e;

    // ------------------------------------------------------------------
    // Window decode
    // ------------------------------------------------------------------
    logic               decode;
    region_e            region;
    logic [ADDR_W-1:0]  ram_addr;
    logic [NSECT_W-1:0] ram_sect;

    assign decode   = cart_on & ~cpu_as_n & (cpu_addr[23:22] == 2'b01);
    assign region   = region_e'(cpu_addr[21:20]);
    // Upper address bits are dropped, so the RAM window aliases.
    assign ram_addr = cpu_addr[ADDR_W:1];
    assign ram_sect = ram_addr[ADDR_W-1:SECT_W];

    // Only the low data byte and part of the address reach the RAM.
    logic unused_bits;
    assign unused_bits = ^{cpu_addr, cpu_dato[15:8]};

    // ------------------------------------------------------------------
    // Write strobe edge detection and register/RAM write path
    // ------------------------------------------------------------------
    logic              we_prev_q;
    logic              wp_q;
    logic              mem_we_q;
    logic [7:0]        mem_din_q;
    logic [ADDR_W-1:0] wr_addr_q;

    logic wr_evt;
    logic ram_wr;
    logic wp_wr;

    // A falling strobe edge yields exactly one event per CPU write cycle.
    assign wr_evt = decode & we_prev_q & ~cpu_we_lo_n;
    // wp=1 means the RAM is writable; writes with wp=0 are dropped entirely.
    assign ram_wr = wr_evt & (region == REGION_RAM) & wp_q;
    assign wp_wr  = wr_evt & (region == REGION_WP);

    // Register the strobe history, the WP bit and the one-cycle BRAM write.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // flop samples the pre-edge values regardless of statement order.
        if (rst) begin
            we_prev_q <= 1'b1;
            wp_q      <= 1'b0;
            mem_we_q  <= 1'b0;
            mem_din_q <= 8'h00;
            wr_addr_q <= '0;
        end else begin
            we_prev_q <= cpu_we_lo_n;
            if (wp_wr) begin
                wp_q <= cpu_dato[0];
            end
            mem_we_q <= ram_wr;
            if (ram_wr) begin
                mem_din_q <= cpu_dato[7:0];
                wr_addr_q <= ram_addr;
            end
        end
    end

    // ------------------------------------------------------------------
    // Bus read path
    // ------------------------------------------------------------------
    // Select the read word for the addressed region.
    always_comb begin
        // NOTE: every combinational output gets a default first so no
        // path through the block leaves it unassigned (no latches).
        cart_dout = 16'hFFFF;
        case (region)
            REGION_ID:       cart_dout = {8'hFF, 4'h0, ID_CODE};
            REGION_UNMAPPED: cart_dout = 16'hFFFF;
            REGION_RAM:      cart_dout = {8'hFF, mem_dout};
            REGION_WP:       cart_dout = {8'hFF, 7'h00, wp_q};
            default:         cart_dout = 16'hFFFF;
        endcase
    end

    assign cart_oe  = decode & ~cpu_oe_n & ~rst;
    // During the write pulse the BRAM must see the captured write address.
    assign mem_addr = mem_we_q ? wr_addr_q : ram_addr;
    assign mem_din  = mem_din_q;
    assign mem_we   = mem_we_q;

    // ------------------------------------------------------------------
    // Dirty tracking and save handshake
    // ------------------------------------------------------------------
    save_state_e        state_q, state_d;
    logic [23:0]        cnt_q, cnt_d;
    logic [NSECT-1:0]   dirty_q, dirty_d;
    logic [NSECT_W-1:0] save_sect_q, save_sect_d;
    logic [NSECT_W-1:0] low_sect;

    // Find the lowest-numbered dirty sector.
    always_comb begin
        low_sect = '0;
        for (int i = NSECT - 1; i >= 0; i--) begin
            if (dirty_q[i]) begin
                low_sect = NSECT_W'(i);
            end
        end
    end

    // Save FSM next state, idle counter and dirty bitmap update.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dirty_d     = dirty_q;
        save_sect_d = save_sect_q;

        // Applied first so a write into the sector being saved keeps it dirty.
        if (ram_wr) begin
            dirty_d[ram_sect] = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (|dirty_q) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (ram_wr) begin
                    cnt_d = '0;
                end else if (cnt_q == IDLE_LAST) begin
                    cnt_d             = '0;
                    state_d           = S_REQ;
                    save_sect_d       = low_sect;
                    dirty_d[low_sect] = 1'b0;
                end else begin
                    cnt_d = cnt_q + 24'd1;
                end
            end
            S_REQ: begin
                cnt_d = '0;
                if (save_ack) begin
                    state_d = (|dirty_d) ? S_WAIT : S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Save FSM state, counter, bitmap and latched sector registers.
    always_ff @(posedge clk) begin
        // NOTE: the dirty bitmap is a flop array, not BRAM, so it is reset
        // like any other register; the backing RAM contents are not.
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            dirty_q     <= '0;
            save_sect_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dirty_q     <= dirty_d;
            save_sect_q <= save_sect_d;
        end
    end

    assign save_req  = (state_q == S_REQ);
    assign save_sect = save_sect_q;
    assign dirty_any = |dirty_q;

endmodule

// File: tb/tb_bram_cart_gen.sv
// Testbench for bram_cart_gen: directed steps plus a randomized write/read
// phase, all checked against a byte-array / sector-set reference model.
module tb_bram_cart_gen;

    localparam int ADDR_W   = 17;
    localparam int SECT_W   = 9;
    localparam int IDLE_CYC = 16;
    localparam int NSECT    = 1 << (ADDR_W - SECT_W);
    localparam int NBYTES   = 1 << ADDR_W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic                     rst;
    logic                     cart_on;
    logic [23:0]              cpu_addr;
    logic [15:0]              cpu_dato;
    logic                     cpu_as_n;
    logic                     cpu_oe_n;
    logic                     cpu_we_lo_n;
    logic [15:0]              cart_dout;
    logic                     cart_oe;
    logic [ADDR_W-1:0]        mem_addr;
    logic [7:0]               mem_din;
    logic                     mem_we;
    logic [7:0]               mem_dout;
    logic                     save_req;
    logic [ADDR_W-SECT_W-1:0] save_sect;
    logic                     save_ack;
    logic                     dirty_any;

    // Second instance only used to see the size ID of the largest RAM.
    logic [15:0] cart_dout_19;
    logic        cart_oe_19;
    logic [18:0] mem_addr_19;
    logic [7:0]  mem_din_19;
    logic        mem_we_19;
    logic        save_req_19;
    logic [9:0]  save_sect_19;
    logic        dirty_any_19;

    bram_cart_gen #(.ADDR_W(ADDR_W), .SECT_W(SECT_W), .IDLE_CYC(IDLE_CYC)) dut (
        .clk(clk), .rst(rst), .cart_on(cart_on), .cpu_addr(cpu_addr),
        .cpu_dato(cpu_dato), .cpu_as_n(cpu_as_n), .cpu_oe_n(cpu_oe_n),
        .cpu_we_lo_n(cpu_we_lo_n), .cart_dout(cart_dout), .cart_oe(cart_oe),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we),
        .mem_dout(mem_dout), .save_req(save_req), .save_sect(save_sect),
        .save_ack(save_ack), .dirty_any(dirty_any)
    );

    bram_cart_gen #(.ADDR_W(19), .SECT_W(9), .IDLE_CYC(IDLE_CYC)) dut19 (
        .clk(clk), .rst(rst), .cart_on(cart_on), .cpu_addr(cpu_addr),
        .cpu_dato(cpu_dato), .cpu_as_n(cpu_as_n), .cpu_oe_n(cpu_oe_n),
        .cpu_we_lo_n(cpu_we_lo_n), .cart_dout(cart_dout_19), .cart_oe(cart_oe_19),
        .mem_addr(mem_addr_19), .mem_din(mem_din_19), .mem_we(mem_we_19),
        .mem_dout(8'h00), .save_req(save_req_19), .save_sect(save_sect_19),
        .save_ack(save_ack), .dirty_any(dirty_any_19)
    );

    // Synchronous BRAM attached to the main instance.
    logic [7:0] bram [NBYTES];
    initial foreach (bram[i]) bram[i] = 8'h00;
    always @(posedge clk) begin
        if (mem_we) bram[mem_addr] <= mem_din;
        mem_dout <= bram[mem_addr];
    end

    // Reference model: expected RAM contents, dirty sector set, WP bit.
    logic [7:0] ref_mem [NBYTES];
    initial foreach (ref_mem[i]) ref_mem[i] = 8'h00;
    bit ref_dirty [NSECT];
    bit ref_wp  = 1'b0;
    int due_cyc = 0;   // cycle count at which the next request should show

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit ref_any();
        foreach (ref_dirty[i]) if (ref_dirty[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int ref_lowest();
        foreach (ref_dirty[i]) if (ref_dirty[i]) return i;
        return -1;
    endfunction

    function automatic logic [15:0] ref_read(input logic [23:0] a);
        case (a[21:20])
            2'b00:   return {8'hFF, 4'h0, 4'(ADDR_W - 13)};
            2'b01:   return 16'hFFFF;
            2'b10:   return {8'hFF, ref_mem[a[ADDR_W:1]]};
            default: return {8'hFF, 7'h00, ref_wp};
        endcase
    endfunction

    // CPU address of a RAM byte, with a chosen alias of the window.
    function automatic logic [23:0] ram_cpu_addr(input int b, input int alias_sel);
        return 24'h600001 | (24'(alias_sel & 3) << 18) | (24'(b & (NBYTES - 1)) << 1);
    endfunction

    // Called at a negedge; one CPU low-byte write cycle spanning several clk.
    task automatic cpu_write(input logic [23:0] addr, input logic [7:0] data, input bit with_ack);
        bit dec, hit_ram, any_before;
        logic [ADDR_W-1:0] ba;
        dec        = cart_on && (addr[23:22] == 2'b01);
        hit_ram    = dec && (addr[21:20] == 2'b10) && ref_wp;
        ba         = addr[ADDR_W:1];
        any_before = ref_any();
        cpu_addr = addr; cpu_dato = {~data, data};
        cpu_as_n = 1'b0; cpu_we_lo_n = 1'b0; save_ack = with_ack;
        @(negedge clk);
        save_ack = 1'b0;
        if (hit_ram) begin
            ref_mem[ba] = data;
            ref_dirty[ba >> SECT_W] = 1'b1;
            // Starting from an idle controller costs one extra clk to enter WAIT.
            due_cyc = cyc + IDLE_CYC + ((any_before || with_ack) ? 0 : 1);
        end
        if (dec && (addr[21:20] == 2'b11)) ref_wp = data[0];
        check("wr_mem_we", mem_we, hit_ram);
        if (hit_ram) begin
            check("wr_mem_addr", mem_addr, ba);
            check("wr_mem_din", mem_din, data);
        end
        check("wr_dirty_any", dirty_any, ref_any());
        if (with_ack) check("wr_ack_req_drop", save_req, 0);
        @(negedge clk);
        check("wr_we_pulse", mem_we, 0);
        @(negedge clk);
        cpu_we_lo_n = 1'b1; cpu_as_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic cpu_read(input string tag, input logic [23:0] addr, input logic [15:0] exp, input bit exp_oe);
        cpu_addr = addr; cpu_as_n = 1'b0; cpu_oe_n = 1'b0;
        @(negedge clk);
        check({tag, "_oe"}, cart_oe, exp_oe);
        if (exp_oe) check(tag, cart_dout, exp);
        cpu_as_n = 1'b1; cpu_oe_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_req(input string tag, input int exp_sect);
        int n = 0;
        while (save_req !== 1'b1 && n < 4 * IDLE_CYC) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_req"}, save_req, 1);
        check({tag, "_lat"}, cyc, due_cyc);
        check({tag, "_sect"}, save_sect, exp_sect);
    endtask

    // Serve every outstanding request lowest-sector-first, then confirm quiet.
    task automatic drain(input string tag);
        int s;
        s = ref_lowest();
        while (s >= 0) begin
            wait_req(tag, s);
            ref_dirty[s] = 1'b0;
            save_ack = 1'b1;
            @(negedge clk);
            save_ack = 1'b0;
            due_cyc = cyc + IDLE_CYC;
            check({tag, "_ack_drop"}, save_req, 0);
            check({tag, "_ack_dirty"}, dirty_any, ref_any());
            s = ref_lowest();
        end
        repeat (IDLE_CYC + 4) @(negedge clk);
        check({tag, "_quiet"}, save_req, 0);
        check({tag, "_clean"}, dirty_any, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] wr_list [$];
        logic [23:0] a;

        // Reset with a decoded read already on the bus.
        rst = 1'b1; cart_on = 1'b1; cpu_addr = 24'h400001; cpu_dato = 16'h0000;
        cpu_as_n = 1'b0; cpu_oe_n = 1'b0; cpu_we_lo_n = 1'b1; save_ack = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cart_oe", cart_oe, 0);
        check("rst_save_req", save_req, 0);
        check("rst_dirty_any", dirty_any, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_din", mem_din, 8'h00);
        check("rst_save_sect", save_sect, 0);
        rst = 1'b0; cpu_as_n = 1'b1; cpu_oe_n = 1'b1;
        @(negedge clk);

        // Register reads and decode qualifiers.
        cpu_addr = 24'h400001; cpu_as_n = 1'b0; cpu_oe_n = 1'b0;
        @(negedge clk);
        check("id_oe", cart_oe, 1);
        check("id_dout", cart_dout, 16'hFF04);
        check("id_dout_19", cart_dout_19, 16'hFF06);
        cpu_as_n = 1'b1; cpu_oe_n = 1'b1;
        @(negedge clk);
        cpu_read("unmapped", 24'h500000, 16'hFFFF, 1'b1);
        cpu_read("wp_rd0", 24'h700001, 16'hFF00, 1'b1);
        cpu_read("outside", 24'h000001, 16'hFFFF, 1'b0);
        cart_on = 1'b0;
        cpu_read("cart_off", 24'h400001, 16'hFFFF, 1'b0);
        cart_on = 1'b1;

        // Write protect: blocked write, then enable and write again.
        cpu_write(24'h600003, 8'hA5, 1'b0);
        check("wp0_dirty", dirty_any, 0);
        cpu_write(24'h400001, 8'h01, 1'b0);
        cpu_write(24'h7FFFFF, 8'h01, 1'b0);
        cpu_read("wp_rd1", 24'h700001, 16'hFF01, 1'b1);
        cpu_write(24'h600003, 8'hA5, 1'b0);
        cpu_read("ram_rd_a5", 24'h600003, 16'hFFA5, 1'b1);

        // Alias: word 0x20000 of the window wraps to byte 0.
        cpu_write(24'h640001, 8'hC3, 1'b0);
        cpu_read("alias_rd", 24'h600001, 16'hFFC3, 1'b1);
        drain("wp_save");

        // Save ordering: sector 2 then sector 0 written; 0 is saved first.
        cpu_write(ram_cpu_addr(16'h0400, 0), 8'h11, 1'b0);
        cpu_write(ram_cpu_addr(16'h0000, 0), 8'h22, 1'b0);
        drain("order");

        // Re-dirty race: write into sector 0 in the same clk as its ack.
        cpu_write(ram_cpu_addr(16'h0000, 1), 8'h33, 1'b0);
        wait_req("race_first", 0);
        ref_dirty[0] = 1'b0;
        cpu_write(ram_cpu_addr(16'h0005, 2), 8'h44, 1'b1);
        check("race_dirty", dirty_any, 1);
        drain("race");

        // Randomized writes across aliases, then saves, then read-back.
        for (int i = 0; i < 30; i++) begin
            a = ram_cpu_addr($urandom_range(0, NBYTES - 1), $urandom_range(0, 3));
            wr_list.push_back(a);
            cpu_write(a, 8'($urandom), 1'b0);
        end
        drain("rnd_save");
        foreach (wr_list[i]) cpu_read("rnd_rd", wr_list[i], ref_read(wr_list[i]), 1'b1);
        for (int i = 0; i < 10; i++) begin
            a = {2'b01, 22'($urandom)};
            cpu_read("rnd_any_rd", a, ref_read(a), 1'b1);
        end

        // Reset in the middle of a pending request.
        cpu_write(ram_cpu_addr(16'h0A00, 0), 8'h55, 1'b0);
        wait_req("rst_mid", 5);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_req", save_req, 0);
        check("rst_mid_dirty", dirty_any, 0);
        rst = 1'b0;
        ref_wp = 1'b0;
        foreach (ref_dirty[i]) ref_dirty[i] = 1'b0;
        cpu_read("rst_mid_wp", 24'h700001, ref_read(24'h700001), 1'b1);
        repeat (2 * IDLE_CYC) @(negedge clk);
        check("rst_mid_quiet", save_req, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bram_cart_gen.md
# bram_cart_gen

Parametrised Mega CD backup-RAM cartridge controller for the mapper layer. Decodes the cartridge window 0x400000–0x7FFFFF and serves the size-ID register, the odd-byte RAM window and the write-protect register. Backs onto byte-wide synchronous BRAM. Tracks dirty sectors and issues a save handshake to the SD-save engine after a programmable write-idle period; RAM size and sector granularity are generic.

## Interface
Parameters:
- ADDR_W, 17, log2 of RAM bytes; legal 13..19; ID code = ADDR_W-13
- SECT_W, 9, log2 of dirty-sector bytes; legal 6..ADDR_W-1; NSECT = 2^(ADDR_W-SECT_W), max 1024
- IDLE_CYC, 1000000, write-free clk cycles before a save is requested; must be ≥1 and < 2^24

Ports:
- clk  in  1  system clock; one clock; reset is synchronous and active-high
- rst  in  1  synchronous active-high reset
- cart_on  in  1  enables window decode
- cpu_addr  in  24  CPU byte address, already synchronous to clk
- cpu_dato  in  16  CPU write data
- cpu_as_n  in  1  address strobe, low-active
- cpu_oe_n  in  1  read strobe, low-active
- cpu_we_lo_n  in  1  low-byte write strobe, low-active
- cart_dout  out  16  read data
- cart_oe  out  1  drive cart_dout onto bus
- mem_addr  out  ADDR_W  BRAM byte address
- mem_din  out  8  BRAM write data
- mem_we  out  1  BRAM write pulse
- mem_dout  in  8  BRAM read data, valid 1 clk after mem_addr
- save_req  out  1  sector save request
- save_sect  out  ADDR_W-SECT_W  sector index to save
- save_ack  in  1  1-cycle acceptance from save engine
- dirty_any  out  1  OR of the dirty bitmap

## Operation
- Decode requires cart_on=1, cpu_as_n=0 and cpu_addr[23:22]=01. Region = cpu_addr[21:20]: 00 ID, 01 unmapped, 10 RAM, 11 WP.
- cart_oe = decode & !cpu_oe_n; forced 0 during rst.
- Read data: ID → {8'hFF,4'h0,ID code}; unmapped → 16'hFFFF; RAM → {8'hFF,mem_dout}; WP → {8'hFF,7'h0,wp}.
- RAM byte address = cpu_addr[ADDR_W:1]; higher bits are ignored, so the window aliases with period 2^ADDR_W words.
- mem_addr follows the decoded RAM address combinationally, except during the mem_we cycle, when it holds the write address.
- Write event = falling edge of cpu_we_lo_n: the registered previous value is 1 and the current value is 0, while decoded. Exactly one event occurs per CPU write cycle.
- RAM write event with wp=1: mem_we=1 for one clk, mem_din=cpu_dato[7:0], and dirty[addr>>SECT_W] set. With wp=0, the write is ignored and no dirty bit is set.
- WP write event: wp ← cpu_dato[0]. Writes to ID or unmapped regions are ignored.
- Save FSM:
  - IDLE: go to WAIT when dirty_any=1.
  - WAIT: the 24-bit idle counter increments each clk and clears on any RAM write event. When it reaches IDLE_CYC-1, go to REQ.
  - REQ: on entry, latch save_sect = lowest set dirty index and clear that bit. Hold save_req=1. On save_ack, go to WAIT with the counter cleared if dirty_any, else go to IDLE.
- Same-cycle set and clear of one dirty bit: set wins. A write that lands during REQ re-dirties the sector, and that sector is saved again later.
- save_ack outside REQ is ignored.

## Timing
- Reset values: wp=0, dirty=0, FSM=IDLE, counter=0, save_req=0, save_sect=0, mem_we=0, mem_din=0, cart_oe=0, dirty_any=0. The edge-detect register is set to 1.
- Write latency: mem_we is asserted in the clk after the sampled strobe edge, and the dirty bit is visible in the same cycle.
- Read latency: 1 clk from address to mem_dout. The CPU strobe spans many clk, so data is stable before the strobe is sampled.
- Save latency: save_req rises IDLE_CYC+1 clk after the last write when the FSM is already in WAIT.
- Simultaneous RAM write event and save_ack: the write is performed, the counter is cleared, and the FSM proceeds to WAIT.
- rst mid-REQ: save_req drops the next clk, and all dirty state is discarded.

## Test plan
- ID read, defaults: read 0x400001 → cart_dout=16'hFF04, cart_oe=1. With ADDR_W=19 → 16'hFF06.
- Write protect: write 0xA5 to 0x600003 with wp=0 → no mem_we, dirty_any=0. Write 0x01 to 0x7FFFFF, repeat the write → mem_we 1 clk at addr 1, din 0xA5. Reading 0x600003 then returns 16'hFFA5.
- Alias/wrap: ADDR_W=17, write to 0x640001 (word 0x20000) → mem_addr=0. Dirty sector 0 set.
- Save ordering: IDLE_CYC=16, write bytes 0x0400 (sector 2) and 0x0000 (sector 0). save_req rises 17 clk after the second write with save_sect=0. After ack, sector 2 follows after another 16 idle clk. dirty_any=0 at the end.
- Re-dirty race: during REQ for sector 0, write byte 0x0005 in the same clk as save_ack → dirty_any stays 1, and a second request for sector 0 follows.
- Reset mid-request: assert rst while save_req=1 → save_req=0, dirty_any=0 and wp=0 next clk. No request appears afterward without new writes.
